// File: rtl/arbiter_pkg.sv
// Shared definitions for the lock_rr_arbiter block.
//   arb_state_e       : arbiter FSM states (IDLE = no grant, OWNED = grant held)
//   DefaultMaxHold    : default hold budget in granted cycles
//   sel_width(n)      : width of an index able to address n requesters
package arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_e;

  localparam int DefaultMaxHold     = 16;
  localparam int DefaultNumRequests = 4;

  function automatic int sel_width(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating priority encoder.
// Searches request bits starting at start_idx, wrapping past NumRequests-1
// to 0, skipping any bit set in exclude. The first eligible bit wins.
// Ports:
//   request   : [0:NumRequests-1] candidate requests
//   start_idx : index where the search begins (must be < NumRequests)
//   exclude   : [0:NumRequests-1] bits that may not win
//   winner    : one-hot of the winning requester, zero when none
//   win_idx   : index of the winning requester, 0 when none
//   found     : high when any eligible request exists
module rr_pick
  import arbiter_pkg::*;
#(
  parameter int NumRequests = DefaultNumRequests,
  parameter int SelW        = sel_width(NumRequests)
) (
  input  logic [0:NumRequests-1] request,
  input  logic [SelW-1:0]        start_idx,
  input  logic [0:NumRequests-1] exclude,
  output logic [0:NumRequests-1] winner,
  output logic [SelW-1:0]        win_idx,
  output logic                   found
);

  always_comb begin
    int pos;
    winner  = '0;
    win_idx = '0;
    found   = 1'b0;
    pos     = 0;
    for (int off = 0; off < NumRequests; off++) begin
      pos = int'(start_idx) + off;
      if (pos >= NumRequests) pos = pos - NumRequests;
      if (!found && request[pos] && !exclude[pos]) begin
        found       = 1'b1;
        winner[pos] = 1'b1;
        win_idx     = SelW'(pos);
      end
    end
  end

endmodule

// File: rtl/lock_rr_arbiter.sv
// Locking request arbiter with optional round-robin rotation and a hold
// budget. A requester keeps the grant while its request stays high; when it
// drops (or the MaxHold budget runs out while others wait) the grant moves
// to the next winner on the same edge, with no idle bubble.
// Ports:
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   request    : [0:NumRequests-1] level requests, bit i = requester i
//   grant      : [0:NumRequests-1] registered one-hot grant (or zero)
//   select     : registered owner index, 0 when idle
//   en_add_gen : registered, high exactly while a grant is held
//   dbg_state  : current FSM state for observation
module lock_rr_arbiter
  import arbiter_pkg::*;
#(
  parameter int NumRequests = DefaultNumRequests,
  parameter bit RoundRobin  = 1'b1,
  parameter int MaxHold     = DefaultMaxHold
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [0:NumRequests-1]              request,
  output logic [0:NumRequests-1]              grant,
  output logic [sel_width(NumRequests)-1:0]   select,
  output logic                                en_add_gen,
  output arb_state_e                          dbg_state
);

  localparam int SelW      = sel_width(NumRequests);
  // A zero budget means unlimited; keep a 1-bit counter so widths stay legal.
  localparam int CntW      = (MaxHold > 0) ? $clog2(MaxHold + 1) : 1;
  localparam bit Unlimited = (MaxHold == 0);

  localparam logic [CntW-1:0] MaxCnt  = CntW'(MaxHold);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [SelW-1:0] LastIdx = SelW'(NumRequests - 1);

  arb_state_e            state_q;
  logic [CntW-1:0]       cnt_q;
  logic [SelW-1:0]       last_q;

  logic [SelW-1:0]        start_idx;
  logic [0:NumRequests-1] pick_onehot;
  logic [SelW-1:0]        pick_idx;
  logic                   pick_found;
  logic                   owner_req;
  logic                   keep;

  // Round-robin search begins just after the last owner; fixed mode always
  // starts at 0 so the lowest index wins.
  always_comb begin
    start_idx = '0;
    if (RoundRobin) begin
      start_idx = (last_q == LastIdx) ? '0 : last_q + SelW'(1);
    end
  end

  // The current owner is excluded, so pick_found means "someone else is
  // waiting" while OWNED and "anyone is requesting" while IDLE (grant is 0).
  rr_pick #(
    .NumRequests (NumRequests),
    .SelW        (SelW)
  ) u_pick (
    .request   (request),
    .start_idx (start_idx),
    .exclude   (grant),
    .winner    (pick_onehot),
    .win_idx   (pick_idx),
    .found     (pick_found)
  );

  assign owner_req = request[select];
  assign keep      = (state_q == OWNED) && owner_req &&
                     (Unlimited || (cnt_q < MaxCnt) || !pick_found);
  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant      <= '0;
      select     <= '0;
      en_add_gen <= 1'b0;
      cnt_q      <= '0;
      last_q     <= LastIdx;
    end else if (keep) begin
      // Owner continues; counter saturates at the budget.
      if (!Unlimited && (cnt_q < MaxCnt)) cnt_q <= cnt_q + CntOne;
    end else if (pick_found) begin
      // Fresh grant from IDLE, or zero-bubble hand-off from OWNED.
      state_q    <= OWNED;
      grant      <= pick_onehot;
      select     <= pick_idx;
      en_add_gen <= 1'b1;
      cnt_q      <= CntOne;
      last_q     <= pick_idx;
    end else begin
      // Nobody requesting: release. last_q is kept for the next rotation.
      state_q    <= IDLE;
      grant      <= '0;
      select     <= '0;
      en_add_gen <= 1'b0;
      cnt_q      <= '0;
    end
  end

endmodule

// File: tb/tb_lock_rr_arbiter.sv
// Directed bench for lock_rr_arbiter. Three instances share clock and reset:
//   dut_a : round-robin, unlimited hold
//   dut_f : fixed priority, default hold budget
//   dut_h : round-robin, hold budget of 4
// Vector literals read left to right as requester 0..3.
module tb_lock_rr_arbiter;
  import arbiter_pkg::*;

  logic clk;
  logic rst_n;

  logic [0:3] req_a, req_f, req_h;
  logic [0:3] grant_a, grant_f, grant_h;
  logic [1:0] sel_a, sel_f, sel_h;
  logic       en_a, en_f, en_h;
  arb_state_e st_a, st_f, st_h;

  int errors;
  int checks;

  lock_rr_arbiter #(.NumRequests(4), .RoundRobin(1'b1), .MaxHold(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .request(req_a), .grant(grant_a),
    .select(sel_a), .en_add_gen(en_a), .dbg_state(st_a)
  );

  lock_rr_arbiter #(.NumRequests(4), .RoundRobin(1'b0), .MaxHold(16)) dut_f (
    .clk(clk), .rst_n(rst_n), .request(req_f), .grant(grant_f),
    .select(sel_f), .en_add_gen(en_f), .dbg_state(st_f)
  );

  lock_rr_arbiter #(.NumRequests(4), .RoundRobin(1'b1), .MaxHold(4)) dut_h (
    .clk(clk), .rst_n(rst_n), .request(req_h), .grant(grant_h),
    .select(sel_h), .en_add_gen(en_h), .dbg_state(st_h)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_a = '0; req_f = '0; req_h = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_a = '0; req_f = '0; req_h = '0;
    @(negedge clk);
    checks++;
    if ({grant_a, grant_f, grant_h} !== 12'b0) begin
      errors++;
      $display("FAIL reset_grant got=%b %b %b exp=0000 0000 0000", grant_a, grant_f, grant_h);
    end
    checks++;
    if ({sel_a, sel_f, sel_h, en_a, en_f, en_h} !== 9'b0) begin
      errors++;
      $display("FAIL reset_sel_en got sel=%0d %0d %0d en=%b%b%b exp sel=0 en=0",
               sel_a, sel_f, sel_h, en_a, en_f, en_h);
    end
    checks++;
    if (st_a !== IDLE || st_f !== IDLE || st_h !== IDLE) begin
      errors++;
      $display("FAIL reset_state got=%0d %0d %0d exp=IDLE", st_a, st_f, st_h);
    end
    rst_n = 1'b1;
  endtask

  // First grant latency, then asynchronous reset mid-grant.
  task automatic test_grant_latency();
    apply_reset();
    @(negedge clk);
    req_h = 4'b0001;
    #1;
    checks++;
    if (grant_h !== 4'b0000) begin
      errors++;
      $display("FAIL latency_pre_edge got=%b exp=0000", grant_h);
    end
    @(posedge clk); #1;
    checks++;
    if (grant_h !== 4'b0001 || sel_h !== 2'd3 || en_h !== 1'b1) begin
      errors++;
      $display("FAIL latency_first_grant got g=%b s=%0d e=%b exp g=0001 s=3 e=1",
               grant_h, sel_h, en_h);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (grant_h !== 4'b0000 || sel_h !== 2'd0 || en_h !== 1'b0 || st_h !== IDLE) begin
      errors++;
      $display("FAIL async_reset got g=%b s=%0d e=%b st=%0d exp g=0000 s=0 e=0 st=IDLE",
               grant_h, sel_h, en_h, st_h);
    end
    @(negedge clk);
    req_h = '0;
    rst_n = 1'b1;
  endtask

  // All four held; each owner drops its request for one cycle after 3 cycles.
  task automatic test_rr_rotation();
    logic [0:3] exp_g [5];
    int         exp_s [5];
    logic [0:3] v;
    exp_g = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
    exp_s = '{0, 1, 2, 3, 0};
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        v = 4'b1111;
        if (c == 0 && i > 0) v[exp_s[i-1]] = 1'b0;
        req_a = v;
        @(posedge clk); #1;
        checks++;
        if (grant_a !== exp_g[i] || sel_a !== 2'(exp_s[i]) || en_a !== 1'b1) begin
          errors++;
          $display("FAIL rr_rotation i=%0d c=%0d got g=%b s=%0d e=%b exp g=%b s=%0d e=1",
                   i, c, grant_a, sel_a, en_a, exp_g[i], exp_s[i]);
        end
      end
    end
    @(negedge clk);
    req_a = '0;
  endtask

  // Fixed priority: lock holds against higher-priority arrivals.
  task automatic test_fixed_priority();
    logic [0:3] vec_r [5];
    logic [0:3] vec_g [5];
    int         vec_s [5];
    vec_r = '{4'b0110, 4'b0110, 4'b0010, 4'b1010, 4'b1000};
    vec_g = '{4'b0100, 4'b0100, 4'b0010, 4'b0010, 4'b1000};
    vec_s = '{1, 1, 2, 2, 0};
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_f = vec_r[i];
      @(posedge clk); #1;
      checks++;
      if (grant_f !== vec_g[i] || sel_f !== 2'(vec_s[i]) || en_f !== 1'b1) begin
        errors++;
        $display("FAIL fixed_priority i=%0d req=%b got g=%b s=%0d e=%b exp g=%b s=%0d e=1",
                 i, vec_r[i], grant_f, sel_f, en_f, vec_g[i], vec_s[i]);
      end
    end
    @(negedge clk);
    req_f = '0;
  endtask

  // MaxHold=4 with requesters 0 and 2 both held: 4 cycles each, alternating.
  task automatic test_forced_handoff();
    logic [0:3] exp;
    apply_reset();
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      req_h = 4'b1010;
      @(posedge clk); #1;
      exp = ((c / 4) % 2 == 0) ? 4'b1000 : 4'b0010;
      checks++;
      if (grant_h !== exp || en_h !== 1'b1) begin
        errors++;
        $display("FAIL forced_handoff c=%0d got g=%b e=%b exp g=%b e=1", c, grant_h, en_h, exp);
      end
    end
    @(negedge clk);
    req_h = '0;
  endtask

  // Lone requester past the budget keeps the grant; a newcomer then takes
  // over on the very next edge because the counter sits at the budget.
  task automatic test_saturate();
    apply_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      req_h = 4'b0100;
      @(posedge clk); #1;
      checks++;
      if (grant_h !== 4'b0100 || sel_h !== 2'd1) begin
        errors++;
        $display("FAIL saturate_hold c=%0d got g=%b s=%0d exp g=0100 s=1", c, grant_h, sel_h);
      end
    end
    @(negedge clk);
    req_h = 4'b1100;
    @(posedge clk); #1;
    checks++;
    if (grant_h !== 4'b1000 || sel_h !== 2'd0) begin
      errors++;
      $display("FAIL saturate_handoff got g=%b s=%0d exp g=1000 s=0", grant_h, sel_h);
    end
    @(negedge clk);
    req_h = '0;
  endtask

  // Owner 3 releases into IDLE; later 1001 wraps to requester 0.
  task automatic test_idle_wrap();
    apply_reset();
    @(negedge clk);
    req_a = 4'b0001;
    @(posedge clk); #1;
    checks++;
    if (grant_a !== 4'b0001 || sel_a !== 2'd3) begin
      errors++;
      $display("FAIL idle_owner3 got g=%b s=%0d exp g=0001 s=3", grant_a, sel_a);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      req_a = 4'b0000;
      @(posedge clk); #1;
      checks++;
      if (grant_a !== 4'b0000 || sel_a !== 2'd0 || en_a !== 1'b0 || st_a !== IDLE) begin
        errors++;
        $display("FAIL idle_release c=%0d got g=%b s=%0d e=%b st=%0d exp g=0000 s=0 e=0 st=IDLE",
                 c, grant_a, sel_a, en_a, st_a);
      end
    end
    @(negedge clk);
    req_a = 4'b1001;
    @(posedge clk); #1;
    checks++;
    if (grant_a !== 4'b1000 || sel_a !== 2'd0 || en_a !== 1'b1) begin
      errors++;
      $display("FAIL idle_wrap got g=%b s=%0d e=%b exp g=1000 s=0 e=1", grant_a, sel_a, en_a);
    end
    @(negedge clk);
    req_a = '0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b1;
    req_a  = '0;
    req_f  = '0;
    req_h  = '0;
    test_reset();
    test_grant_latency();
    test_rr_rotation();
    test_fixed_priority();
    test_forced_handoff();
    test_saturate();
    test_idle_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lock_rr_arbiter.md
# lock_rr_arbiter

Registered, parametrised successor to the combinational fixed-priority request arbiter. It selects one of `NumRequests` requesters, holds (locks) the grant while that requester keeps its request asserted, and rotates priority round-robin when `RoundRobin` is set. A `MaxHold` budget forces a hand-off when other requesters are waiting. It sits in front of the shared address generator: `select` steers the datapath mux and `en_add_gen` enables the generator.

## Interface
- `NumRequests`, default 4: number of requesters; legal range ≥2.
- `RoundRobin`, default 1:
  - 1 = rotating priority.
  - 0 = fixed priority, index 0 highest.
- `MaxHold`, default 16: maximum granted cycles before a forced hand-off; 0 = unlimited.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `request` input [0:NumRequests-1]: level requests; bit i belongs to requester i.
- `grant` output [0:NumRequests-1]: registered, one-hot or zero.
- `select` output [$clog2(NumRequests)-1:0]: registered index of the granted requester.
- `en_add_gen` output 1: registered; high exactly when `grant` is non-zero.

## Operation
- States: IDLE (no grant) and OWNED (one requester holds the grant).
- IDLE → OWNED: any `request` bit is high at the edge. The winner is picked by the priority scheme. The counter is loaded to 1.
- OWNED → OWNED, same owner: the owner's request is high, and either the counter < `MaxHold`, or `MaxHold`=0, or no other request is pending. The counter increments and saturates at `MaxHold`.
- OWNED → OWNED, new owner (hand-off):
  - Triggers: the owner's request is low and another request is high, or the counter = `MaxHold` (`MaxHold`≠0) and another request is high.
  - The winner is picked excluding the current owner. The counter is reloaded to 1.
- OWNED → IDLE: the owner's request is low and no other request is high.
- Priority scheme:
  - Fixed mode: lowest set index wins.
  - Round-robin mode: the search starts at (last owner + 1) mod `NumRequests` and wraps past `NumRequests`-1 to 0.
  - The last-owner pointer updates on every new grant. It is retained through IDLE.
- `select` holds the owner index while OWNED. It is 0 in IDLE; high-Z is never driven.
- A request dropped and re-raised by the owner within the same cycle window is not visible. Only sampled levels matter.

## Timing
- Reset (async assert, synchronous deassert handled upstream): `grant`=0, `select`=0, `en_add_gen`=0, state IDLE, counter 0, last-owner pointer = `NumRequests`-1, so requester 0 has first priority.
- Grant latency: a request sampled high at edge k produces `grant` after edge k, when the arbiter is free.
- Hand-off is zero-bubble. If the owner's request is low at edge k and another request is pending, the new grant appears after the same edge k, with no IDLE cycle.
- Forced hand-off: with `MaxHold`=M, the owner holds `grant` for exactly M consecutive cycles if others wait, then loses it at the next edge.
- Simultaneous requests: exactly one grant. Ties are resolved by the priority scheme only.
- `rst_n` asserted mid-grant clears all outputs immediately, without waiting for a clock edge.

## Structure
- Package `arbiter_pkg`:
  - State enum `arb_state_e` {IDLE, OWNED}.
  - Function `sel_width(n)` = `$clog2(n)`.
  - Shared constants for the default `MaxHold`.
- Sub-module `rr_pick`: purely combinational rotating priority encoder.
  - Inputs: request vector, start index, exclude mask.
  - Outputs: winner one-hot, winner index, found.
  - Fixed mode instantiates it with start index 0.
- Top level: state register, hold counter (width `$clog2(MaxHold+1)`), last-owner register, output registers.

## Test plan
- Reset, then `request`=0001 (bit 3 set) at edge 1 → after edge 1: `grant`=0001, `select`=3, `en_add_gen`=1. Assert `rst_n` low mid-grant → outputs are 0 immediately.
- `RoundRobin`=1, `MaxHold`=0, all four requests held, each owner drops its request for one cycle after 3 cycles → owners follow 0,1,2,3,0 with zero-bubble hand-offs.
- `RoundRobin`=0, `request`=0110, then bit 1 drops → grant 1 first, then 2 on the next edge; `select` goes 1→2.
- `MaxHold`=4, requesters 0 and 2 both held high → requester 0 is granted for exactly 4 cycles, then requester 2 for 4 cycles, alternating.
- `MaxHold`=4, only requester 1 held for 10 cycles → the grant stays on requester 1 all 10 cycles (counter saturates, no hand-off).
- Owner 3 releases with no other request → IDLE: `grant`=0, `select`=0, `en_add_gen`=0. Later, `request`=1001 in RR mode with last owner 3 → requester 0 wins (wrap-around).
